// File: rtl/maze_if.sv
// maze_if: start/busy/done handshake plus the generated wall vectors
interface maze_if;
  logic start;
  logic busy;
  logic done;
  logic [159:0] h_walls;
  logic [164:0] v_walls;
  modport master(output start, input busy, done, h_walls, v_walls);
  modport slave(input start, output busy, done, h_walls, v_walls);
endinterface

// File: rtl/maze_generator.sv
// maze_generator: sidewinder perfect-maze generator over a 10x15 cell grid driven by a Galois LFSR
module maze_generator #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int MAX_RETRY = 7
) (
  input logic clk,
  input logic rst,
  maze_if.slave m
);
  localparam int RW = (MAX_RETRY > 7) ? $clog2(MAX_RETRY + 1) : 3;
  typedef enum logic [2:0] {IDLE, INIT, TOP, WALK, PICK, DONE} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [3:0] row, col, run_start, span, len, off;
  logic [RW-1:0] retry_cnt;
  logic [7:0] h_idx, v_idx;
  logic forced, pick, close;
  always_comb begin
    span = col - run_start;
    len = span + 4'd1;
    forced = retry_cnt == RW'(MAX_RETRY);
    pick = forced | (lfsr[3:0] < len);
    off = forced ? span : lfsr[3:0];
    close = (col == 4'd9) | lfsr[0];
    h_idx = 8'(row) * 8'd10 + 8'(run_start) + 8'(off);
    v_idx = 8'(row) * 8'd11 + 8'(col) + 8'd1;
  end
  // the LFSR free-runs outside reset so the maze depends on when start arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
      state <= IDLE;
      row <= '0;
      col <= '0;
      run_start <= '0;
      retry_cnt <= '0;
      m.busy <= 1'b0;
      m.done <= 1'b0;
      m.h_walls <= '1;
      m.v_walls <= '1;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      case (state)
        IDLE: if (m.start) begin
          m.busy <= 1'b1;
          state <= INIT;
        end
        INIT: begin
          m.h_walls <= '1;
          m.v_walls <= '1;
          state <= TOP;
        end
        TOP: begin
          m.v_walls[9:1] <= '0;
          row <= 4'd1;
          col <= '0;
          run_start <= '0;
          state <= WALK;
        end
        WALK: if (close) begin
          retry_cnt <= '0;
          state <= PICK;
        end else begin
          m.v_walls[v_idx] <= 1'b0;
          col <= col + 4'd1;
        end
        PICK: if (!pick) retry_cnt <= retry_cnt + 1'b1;
        else begin
          m.h_walls[h_idx] <= 1'b0;
          run_start <= col + 4'd1;
          if (col < 4'd9) begin
            col <= col + 4'd1;
            state <= WALK;
          end else if (row < 4'd14) begin
            row <= row + 4'd1;
            col <= '0;
            run_start <= '0;
            state <= WALK;
          end else begin
            m.done <= 1'b1;
            m.busy <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          m.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
